// File: rtl/ar_arb_mux_if.sv
// AR-channel bundle for ar_arb_mux: NUM_SRC packed sender channels in, one
// receiver channel out. The slave modport is the arbiter's view; master is the environment's.
interface ar_arb_mux_if #(
  parameter int NUM_SRC    = 4,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]            s_valid;
  logic [NUM_SRC*ID_WIDTH-1:0]   s_id;
  logic [NUM_SRC*ADDR_WIDTH-1:0] s_addr;
  logic [NUM_SRC*LEN_WIDTH-1:0]  s_len;
  logic [NUM_SRC*3-1:0]          s_size;
  logic [NUM_SRC*2-1:0]          s_burst;
  logic [NUM_SRC*4-1:0]          s_qos;
  logic [NUM_SRC-1:0]            s_ready;
  logic                          m_valid;
  logic [SRC_W+ID_WIDTH-1:0]     m_id;
  logic [ADDR_WIDTH-1:0]         m_addr;
  logic [LEN_WIDTH-1:0]          m_len;
  logic [2:0]                    m_size;
  logic [1:0]                    m_burst;
  logic [3:0]                    m_qos;
  logic                          m_ready;

  modport slave (
    input  s_valid, s_id, s_addr, s_len, s_size, s_burst, s_qos, m_ready,
    output s_ready, m_valid, m_id, m_addr, m_len, m_size, m_burst, m_qos
  );

  modport master (
    output s_valid, s_id, s_addr, s_len, s_size, s_burst, s_qos, m_ready,
    input  s_ready, m_valid, m_id, m_addr, m_len, m_size, m_burst, m_qos
  );
endinterface

// File: rtl/ar_arb_mux.sv
// QoS-first, round-robin AR arbiter with a one-deep registered output stage.
// Define AR_ARB_AGE_EN to add per-source starvation counters that override QoS.
module ar_arb_mux #(
  parameter int NUM_SRC    = 4,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int AGE_LIMIT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  ar_arb_mux_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_SRC);

  if (NUM_SRC < 2 || NUM_SRC > 16 || AGE_LIMIT < 1) begin : g_bad_cfg
    $error("ar_arb_mux: unsupported NUM_SRC/AGE_LIMIT");
  end

  logic [SRC_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      m_valid_q, m_valid_d;
  logic [SRC_W+ID_WIDTH-1:0] m_id_q, m_id_d;
  logic [ADDR_WIDTH-1:0]     m_addr_q, m_addr_d;
  logic [LEN_WIDTH-1:0]      m_len_q, m_len_d;
  logic [2:0]                m_size_q, m_size_d;
  logic [1:0]                m_burst_q, m_burst_d;
  logic [3:0]                m_qos_q, m_qos_d;

  logic [NUM_SRC-1:0] keep;
  logic [3:0]         max_qos;
  logic               win_found;
  logic [SRC_W-1:0]   win_idx;
  logic               open, grant;
  int                 widx;

`ifdef AR_ARB_AGE_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0]   age_q [NUM_SRC];
  logic [NUM_SRC-1:0] aged;

  always_comb begin
    aged = '0;
    for (int i = 0; i < NUM_SRC; i++)
      aged[i] = bus.s_valid[i] && (age_q[i] >= AGE_W'(AGE_LIMIT));
  end

  // Waiting time of each pending request; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst || !bus.s_valid[i] || bus.s_ready[i]) age_q[i] <= '0;
      else if (age_q[i] != '1)                     age_q[i] <= age_q[i] + 1'b1;
    end
  end
`endif

  always_comb begin
    max_qos = '0;
    keep    = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (bus.s_valid[i] && (bus.s_qos[i*4 +: 4] > max_qos)) max_qos = bus.s_qos[i*4 +: 4];
    for (int i = 0; i < NUM_SRC; i++)
      keep[i] = bus.s_valid[i] && (bus.s_qos[i*4 +: 4] == max_qos);
`ifdef AR_ARB_AGE_EN
    if (|aged) keep = aged;
`endif
  end

  // Rotating scan starting at rr_ptr; the first surviving candidate wins.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!win_found && keep[j[SRC_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = j[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    open        = !m_valid_q || bus.m_ready;
    grant       = open && win_found && !rst;
    widx        = int'(win_idx);
    bus.s_ready = '0;
    if (grant) bus.s_ready[win_idx] = 1'b1;

    m_valid_d = m_valid_q;
    rr_ptr_d  = rr_ptr_q;
    m_id_d    = m_id_q;
    m_addr_d  = m_addr_q;
    m_len_d   = m_len_q;
    m_size_d  = m_size_q;
    m_burst_d = m_burst_q;
    m_qos_d   = m_qos_q;
    if (grant) begin
      m_valid_d = 1'b1;
      m_id_d    = {win_idx, bus.s_id[widx*ID_WIDTH +: ID_WIDTH]};
      m_addr_d  = bus.s_addr[widx*ADDR_WIDTH +: ADDR_WIDTH];
      m_len_d   = bus.s_len[widx*LEN_WIDTH +: LEN_WIDTH];
      m_size_d  = bus.s_size[widx*3 +: 3];
      m_burst_d = bus.s_burst[widx*2 +: 2];
      m_qos_d   = bus.s_qos[widx*4 +: 4];
      rr_ptr_d  = (win_idx == SRC_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Output stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      rr_ptr_q  <= '0;
      m_id_q    <= '0;
      m_addr_q  <= '0;
      m_len_q   <= '0;
      m_size_q  <= '0;
      m_burst_q <= '0;
      m_qos_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      rr_ptr_q  <= rr_ptr_d;
      m_id_q    <= m_id_d;
      m_addr_q  <= m_addr_d;
      m_len_q   <= m_len_d;
      m_size_q  <= m_size_d;
      m_burst_q <= m_burst_d;
      m_qos_q   <= m_qos_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_id    = m_id_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_len   = m_len_q;
  assign bus.m_size  = m_size_q;
  assign bus.m_burst = m_burst_q;
  assign bus.m_qos   = m_qos_q;
endmodule

// File: tb/tb_ar_arb_mux.sv
// Scoreboard bench for ar_arb_mux: a queue-based reference model predicts grants
// and transfers; a separate monitor compares every presented output transfer.
`timescale 1ns/1ps
module tb_ar_arb_mux;
  localparam int N   = 4;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int LW  = 8;
  localparam int SW  = 2;
  localparam int AGE = 3;
  localparam int TW  = SW + IDW + AW + LW + 3 + 2 + 4;

  typedef logic [TW-1:0] txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ar_arb_mux_if #(.NUM_SRC(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  ar_arb_mux #(.NUM_SRC(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
               .AGE_LIMIT(AGE)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [IDW-1:0] ids   [N];
  logic [AW-1:0]  addrs [N];
  logic [LW-1:0]  lens  [N];
  logic [2:0]     sizes [N];
  logic [1:0]     bursts[N];
  logic [3:0]     qoss  [N];
  logic [N-1:0]   vld  = '1;
  logic           mrdy = 1'b1;

  always_comb begin
    bus.s_valid = vld;
    bus.m_ready = mrdy;
    bus.s_id    = '0;
    bus.s_addr  = '0;
    bus.s_len   = '0;
    bus.s_size  = '0;
    bus.s_burst = '0;
    bus.s_qos   = '0;
    for (int i = 0; i < N; i++) begin
      bus.s_id[i*IDW +: IDW] = ids[i];
      bus.s_addr[i*AW +: AW] = addrs[i];
      bus.s_len[i*LW +: LW]  = lens[i];
      bus.s_size[i*3 +: 3]   = sizes[i];
      bus.s_burst[i*2 +: 2]  = bursts[i];
      bus.s_qos[i*4 +: 4]    = qoss[i];
    end
  end

  int         n_chk = 0;
  int         n_fail = 0;
  txn_t       sb[$];
  int         rr = 0;
  bit         exp_mv = 1'b0;
  int         age_cnt[N];
  int         last_win;
  logic [N-1:0] last_sready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: evaluated once per cycle after inputs settle.
  task automatic model_step();
    int cand[$];
    int kept[$];
    int maxq;
    int win;
    int s;
    check("m_valid", 64'(bus.m_valid), 64'(exp_mv));
    win = -1;
    if (!rst && (!exp_mv || mrdy)) begin
      for (int i = 0; i < N; i++) if (vld[i]) cand.push_back(i);
      if (cand.size() > 0) begin
        maxq = -1;
        foreach (cand[c]) if (int'(qoss[cand[c]]) > maxq) maxq = int'(qoss[cand[c]]);
        foreach (cand[c]) if (int'(qoss[cand[c]]) == maxq) kept.push_back(cand[c]);
`ifdef AR_ARB_AGE_EN
        begin
          int old[$];
          foreach (cand[c]) if (age_cnt[cand[c]] >= AGE) old.push_back(cand[c]);
          if (old.size() > 0) kept = old;
        end
`endif
        for (int k = 0; k < N && win < 0; k++) begin
          s = (rr + k) % N;
          foreach (kept[m]) if (kept[m] == s) win = s;
        end
      end
    end
    check("s_ready", 64'(bus.s_ready), (win < 0) ? 64'd0 : (64'd1 << win));
    last_sready = bus.s_ready;
    last_win    = win;
    if (rst) begin
      exp_mv = 1'b0;
      rr     = 0;
      sb.delete();
    end else if (win >= 0) begin
      sb.push_back({SW'(win), ids[win], addrs[win], lens[win], sizes[win], bursts[win], qoss[win]});
      exp_mv = 1'b1;
      rr     = (win + 1) % N;
    end else if (mrdy) begin
      exp_mv = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (rst || !vld[i] || win == i) age_cnt[i] = 0;
      else if (age_cnt[i] < AGE)      age_cnt[i] = age_cnt[i] + 1;
    end
  endtask

  // Inputs change only at negedges; the model runs 1ns later.
  task automatic cyc(input logic r, input logic [N-1:0] v, input logic mr);
    rst  = r;
    vld  = v;
    mrdy = mr;
    #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < N; i++) begin
      ids[i]    = IDW'($urandom);
      addrs[i]  = $urandom;
      lens[i]   = LW'($urandom);
      sizes[i]  = 3'($urandom);
      bursts[i] = 2'($urandom);
      qoss[i]   = 4'($urandom_range(0, 3));
    end
  endtask

  initial begin : monitor
    txn_t act;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.m_valid) begin
        act = {bus.m_id, bus.m_addr, bus.m_len, bus.m_size, bus.m_burst, bus.m_qos};
        if (sb.size() == 0) begin
          check("m_orphan", 64'(act), 64'(txn_t'(0)) ^ 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("m_payload", 64'(act), 64'(sb[0]));
          if (mrdy) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : stim
    int seq[5] = '{0, 1, 2, 3, 0};
    int first0;
    for (int i = 0; i < N; i++) age_cnt[i] = 0;
    randomize_payload();
    @(negedge clk);

    cyc(1'b1, 4'b1111, 1'b1);
    cyc(1'b1, 4'b1111, 1'b1);
    check("rst_m_addr", 64'(bus.m_addr), 64'd0);
    check("rst_m_id", 64'(bus.m_id), 64'd0);

    for (int i = 0; i < N; i++) qoss[i] = 4'h1;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 4'b1111, 1'b1);
      check("rr_order", 64'(last_sready), 64'd1 << seq[k]);
    end

    qoss[2] = 4'hA;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 4'b1111, 1'b1);
      check("qos_pick", 64'(last_sready), 64'h4);
    end

    qoss[2] = 4'h1;
    cyc(1'b0, 4'b0001, 1'b1);
    addrs[1] = 32'h1000;
    cyc(1'b0, 4'b1111, 1'b1);
    check("bp_grant1", 64'(last_sready), 64'h2);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 4'b1111, 1'b0);
      check("bp_sready", 64'(last_sready), 64'h0);
      check("bp_addr", 64'(bus.m_addr), 64'h1000);
      check("bp_valid", 64'(bus.m_valid), 64'd1);
    end
    cyc(1'b0, 4'b1111, 1'b1);
    check("bp_release", 64'(last_sready), 64'h4);

    cyc(1'b0, 4'b1000, 1'b1);
    check("wrap3", 64'(last_sready), 64'h8);
    cyc(1'b0, 4'b1001, 1'b1);
    check("wrap0", 64'(last_sready), 64'h1);

    qoss[0] = 4'h0;
    qoss[1] = 4'hF;
    first0  = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 4'b0011, 1'b1);
      if (last_sready[0] && first0 == 0) first0 = k;
    end
`ifdef AR_ARB_AGE_EN
    check("age_grant", 64'((first0 >= 1) && (first0 <= 5)), 64'd1);
`else
    check("no_age_grant", 64'(first0), 64'd0);
`endif

    for (int k = 0; k < 3000; k++) begin
      randomize_payload();
      cyc(($urandom_range(0, 199) == 0), N'($urandom), ($urandom_range(0, 9) < 7));
    end

    for (int k = 0; k < 3; k++) cyc(1'b0, 4'b0000, 1'b1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ar_arb_mux.md
Name: ar_arb_mux

Overview:
- N-input AXI read-address (AR) arbiter/multiplexer that merges NUM_SRC AR sender channels into one AR receiver channel.
- Selects by QoS (highest wins), breaks ties round-robin, and registers the winner in a one-deep output stage.
- Widens the outgoing ID with the source index so the R-channel return path can route responses back.
- Sits between the master-side AR channels and the single downstream memory/interconnect port.

Parameters:
- NUM_SRC, 4, number of input AR channels (2..16).
- ID_WIDTH, 4, per-source transaction ID width.
- ADDR_WIDTH, 32, address width.
- LEN_WIDTH, 8, burst length width.
- SRC_W, $clog2(NUM_SRC), source-index width (derived, not overridden).
- AGE_LIMIT, 15, starvation threshold in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  NUM_SRC  per-source AR valid
- s_id  in  NUM_SRC*ID_WIDTH  packed IDs; source i at [i*ID_WIDTH +: ID_WIDTH]
- s_addr  in  NUM_SRC*ADDR_WIDTH  packed addresses
- s_len  in  NUM_SRC*LEN_WIDTH  packed burst lengths
- s_size  in  NUM_SRC*3  packed beat sizes
- s_burst  in  NUM_SRC*2  packed burst types
- s_qos  in  NUM_SRC*4  packed QoS
- s_ready  out  NUM_SRC  one-hot grant/accept
- m_valid  out  1  output AR valid
- m_id  out  SRC_W+ID_WIDTH  {source index, source id}
- m_addr  out  ADDR_WIDTH  address
- m_len  out  LEN_WIDTH  burst length
- m_size  out  3  beat size
- m_burst  out  2  burst type
- m_qos  out  4  QoS passed through unchanged
- m_ready  in  1  downstream ready

Behaviour:
- Clocking: single clock; all state updates on the rising edge of clk; rst is synchronous, active-high.
- Reset:
  - m_valid=0; all m_* payload outputs=0.
  - Round-robin pointer rr_ptr=0.
  - s_ready=0 while rst=1, regardless of inputs.
- Output stage:
  - Register is "open" when m_valid=0 or m_ready=1.
  - A grant occurs only when the register is open and at least one s_valid=1.
- Arbitration (combinational, evaluated every cycle):
  - Candidates are the sources with s_valid=1.
  - Keep only candidates whose s_qos equals the maximum s_qos among candidates.
  - Winner is the first kept candidate at or after rr_ptr, scanning upward with modulo-NUM_SRC wrap.
- s_ready:
  - One-hot on the winner when a grant occurs, else all 0.
  - Never more than one bit set.
  - Depends combinationally on m_ready and s_valid; no dependency on s_ready feeds back into s_valid.
- On grant (edge):
  - Payload of the winner is loaded into the output register.
  - m_id <= {winner index, s_id[winner]}; m_valid <= 1.
  - rr_ptr <= (winner+1) mod NUM_SRC.
- Accept with no grant: m_valid=1, m_ready=1, no s_valid → m_valid <= 0; payload holds its last value.
- Stability: while m_valid=1 and m_ready=0, all m_* outputs stay constant and s_ready stays 0.
- Latency and throughput: 1 cycle from s_valid/s_ready handshake to m_valid; one transfer per cycle sustained when m_ready=1.
- rr_ptr changes only on a grant.
- Source behaviour:
  - Sources may drop s_valid without a handshake; the arbiter re-evaluates every cycle and holds no lock.
  - Grants never split a burst; each AR beat is a complete transaction.
- Reset mid-operation: a pending m_valid is dropped; no grant is issued in the reset cycle.

Optional Feature:
- Macro: AR_ARB_AGE_EN.
- When defined:
  - Each source has a saturating wait counter (width $clog2(AGE_LIMIT+1)).
  - Counter increments each cycle that s_valid=1 and s_ready=0.
  - Counter clears on grant, on s_valid=0, and on rst.
  - A source whose counter ≥ AGE_LIMIT is "aged".
  - If any candidate is aged, only aged candidates are considered and QoS is ignored; the round-robin tie-break still applies.
- When undefined: no counters exist; pure QoS + round-robin as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with s_valid=4'b1111 → s_ready=0, m_valid=0, m_* =0.
- Equal QoS, all valid, m_ready=1:
  - Grants in order 0,1,2,3,0.
  - m_id[5:4] sequence 0,1,2,3,0; one transfer per cycle.
- QoS priority: s_qos source2=4'hA, others 4'h1, all valid → source2 is granted every cycle; m_qos=4'hA; m_id={2'd2, s_id[2]}.
- Backpressure:
  - Grant source1 (addr 32'h1000); then m_ready=0 for 5 cycles.
  - m_addr stays 32'h1000, m_valid stays 1, s_ready=0 throughout.
  - On m_ready=1, source with the next round-robin pointer (2) is granted in the same cycle.
- Wrap and pointer:
  - Only source3 valid → grant 3, rr_ptr wraps to 0.
  - Then sources 0 and 3 valid → source0 granted.
- AR_ARB_AGE_EN, AGE_LIMIT=3:
  - Source0 qos=0, source1 qos=F, both continuously valid, m_ready=1.
  - Source0 is granted within 5 cycles of first s_valid.
  - Without the macro, source0 is never granted.
